id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of A/B/Ext/index/pc fields.
REQ-002 SHALL have parameter CNT_W, default 16, width of the bubble and flush statistics counters.
REQ-003 SHALL have ports, clock and reset first:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  id_valid  in  1  ID holds a real instruction
  id_ctrl  in  11  {ALUsrc,j,jr,jal,bne,beq,blez,memread,memwrite,regwrite,memtoreg}
  id_op  in  4  ALU opcode
  id_a, id_b, id_ext, id_index, id_pc  in  DATA_W each  operands, extended immediate, jump index, PC
  id_rs, id_rt, id_rd  in  5 each  register specifiers
  id_uses_rt  in  1  ID instruction reads rt as a source
  stall  in  1  global pipeline hold
  flush  in  1  EX misprediction (inverted correct_b), kill ID instruction
  ex_valid  out  1  EX-side instruction valid
  ex_ctrl, ex_op, ex_a, ex_b, ex_ext, ex_index, ex_pc, ex_rs, ex_rt, ex_rd  out  as inputs  registered copies
  load_use  out  1  combinational hazard request to hold PC and IF/ID
  bubble_cnt, flush_cnt  out  CNT_W each  saturating statistics

Function
REQ-004 SHALL register all ex_* outputs on rising clk; latency ID to EX exactly 1 cycle.
REQ-005 SHALL compute load_use = ex_valid & ex_ctrl.memread & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
REQ-006 SHALL resolve each edge by priority: flush > stall > load_use > normal load.
REQ-007 flush: SHALL load a bubble (ex_valid=0, ex_ctrl=0, ex_op=0, data fields don't-care) regardless of stall/load_use.
REQ-008 stall without flush: SHALL hold every ex_* register unchanged; counters unchanged.
REQ-009 load_use without flush/stall: SHALL load a bubble, leaving ID instruction for re-presentation next cycle.
REQ-010 normal: SHALL load ex_valid=id_valid and all id_* fields; id_valid=0 SHALL force ex_ctrl=0.
REQ-011 bubble_cnt SHALL increment by 1 on each REQ-009 edge, saturating at all-ones.
REQ-012 flush_cnt SHALL increment by 1 on each REQ-007 edge with id_valid=1, saturating at all-ones.
REQ-013 load_use SHALL be 0 whenever ex_valid=0, so a bubble never triggers a second bubble.
REQ-014 back-to-back load-use (load followed by two dependents) SHALL insert exactly one bubble; second dependent proceeds normally.
REQ-015 rs/rt of 0 SHALL never cause a hazard.

Reset
REQ-016 rst_n low SHALL asynchronously force ex_valid=0, ex_ctrl=0, ex_op=0, all data/specifier fields 0, both counters 0.
REQ-017 reset deassertion SHALL be synchronous to clk in the enclosing design; first edge after release SHALL behave per REQ-006.
REQ-018 reset mid-stall or mid-bubble SHALL discard held state; no hazard pending after reset.

Structure
REQ-019 control-bit index constants (CTRL_ALUSRC..CTRL_MEMTOREG), CTRL_W=11 and OP_W=4 SHALL live in the shared CPU package used by ID and EX.
REQ-020 hazard detection SHALL be a sub-module load_use_detect (purely combinational), instantiated once; registers and counters in id_ex_reg.

Verification
REQ-021 Reset: rst_n=0 mid-cycle with ex_valid=1 -> all outputs 0 immediately, counters 0.
REQ-022 Load-use: EX holds lw rt=5, ID add rs=5 -> load_use=1, next edge ex_valid=0, bubble_cnt=1; following edge add enters EX.
REQ-023 No hazard: EX lw rt=0, ID rs=0 -> load_use=0, instruction passes in 1 cycle.
REQ-024 Flush+stall same cycle, id_valid=1 -> bubble loaded, flush_cnt=1, bubble_cnt unchanged.
REQ-025 Stall 3 cycles with ex_a=0x1234_5678 -> ex_* stable all 3 cycles, load_use evaluation unchanged.
REQ-026 Saturation: CNT_W=4, 20 load-use events -> bubble_cnt=15 thereafter.

Source files
------------

// File: rtl/id_ex_reg_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_reg_pkg
// Shared CPU package used by the ID and EX stages.
//   - Control-bus layout: CTRL_W-wide bus ordered
//     {ALUsrc,j,jr,jal,bne,beq,blez,memread,memwrite,regwrite,memtoreg},
//     so ALUsrc is the MSB and memtoreg is bit 0.
//   - ALU opcode width OP_W and register-specifier width REG_W.
//   - ex_action_e: what the ID/EX register does on a given clock edge.
//   - pick_action(): resolves flush > stall > load_use > normal load.
//   - reg_hit(): producer/consumer register match in which r0 never matches.
// -----------------------------------------------------------------------------
package id_ex_reg_pkg;

  localparam int CTRL_W = 11;
  localparam int OP_W   = 4;
  localparam int REG_W  = 5;

  // Bit positions inside the control bus.
  localparam int CTRL_ALUSRC   = 10;
  localparam int CTRL_J        = 9;
  localparam int CTRL_JR       = 8;
  localparam int CTRL_JAL      = 7;
  localparam int CTRL_BNE      = 6;
  localparam int CTRL_BEQ      = 5;
  localparam int CTRL_BLEZ     = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,  // capture the ID instruction
    ACT_HOLD   = 2'd1,  // global stall: keep everything
    ACT_BUBBLE = 2'd2,  // load-use hazard: insert a bubble
    ACT_FLUSH  = 2'd3   // misprediction: kill the ID instruction
  } ex_action_e;

  // Priority resolution for one clock edge.
  function automatic ex_action_e pick_action(input logic flush,
                                             input logic stall,
                                             input logic load_use);
    ex_action_e act;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (stall) begin
      act = ACT_HOLD;
    end else if (load_use) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_LOAD;
    end
    return act;
  endfunction

  // True when consumer reads the register the producer writes; r0 is
  // hard-wired to zero and never creates a dependency.
  function automatic logic reg_hit(input logic [REG_W-1:0] producer,
                                   input logic [REG_W-1:0] consumer);
    return (producer != {REG_W{1'b0}}) && (producer == consumer);
  endfunction

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector. It flags the case where
// the instruction in EX is a load whose destination (rt) is read by the
// instruction sitting in ID. A bubble in EX (ex_valid=0) never raises the
// request, so one bubble cannot trigger a second one.
// Ports:
//   ex_valid, ex_memread, ex_rt     - EX-side load information
//   id_valid, id_rs, id_rt          - ID-side source specifiers
//   id_uses_rt                      - ID instruction reads rt as a source
//   load_use                        - hazard request (hold PC and IF/ID)
// -----------------------------------------------------------------------------
module load_use_detect
  import id_ex_reg_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use
);

  logic rs_hit_s;
  logic rt_hit_s;

  // Match the loaded register against both possible ID sources.
  always_comb begin
    rs_hit_s = reg_hit(ex_rt, id_rs);
    rt_hit_s = id_uses_rt & reg_hit(ex_rt, id_rt);
    load_use = ex_valid & ex_memread & id_valid & (rs_hit_s | rt_hit_s);
  end

endmodule

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register with load-use bubble insertion, flush on
// misprediction, global stall and saturating statistics counters.
// Each edge does exactly one of: flush (bubble), hold (stall),
// hazard bubble (load_use), or normal capture of the ID instruction.
// Ports:
//   clk, rst_n                              - clock, async active-low reset
//   id_valid, id_ctrl, id_op                - ID instruction valid/control/op
//   id_a, id_b, id_ext, id_index, id_pc     - ID datapath fields
//   id_rs, id_rt, id_rd, id_uses_rt         - register specifiers
//   stall, flush                            - pipeline hold / kill ID
//   ex_*                                    - registered EX-side copies
//   load_use                                - combinational hazard request
//   bubble_cnt, flush_cnt                   - saturating event counters
// -----------------------------------------------------------------------------
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [OP_W-1:0]   id_op,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [DATA_W-1:0] id_ext,
  input  logic [DATA_W-1:0] id_index,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rt,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [OP_W-1:0]   ex_op,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_ext,
  output logic [DATA_W-1:0] ex_index,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              load_use,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ex_action_e action_s;

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  load_use_detect u_load_use_detect (
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl[CTRL_MEMREAD]),
    .ex_rt      (ex_rt),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  // Decide what this edge does; flush beats stall beats the hazard bubble.
  always_comb begin
    action_s = pick_action(flush, stall, load_use);
  end

  // Pipeline register and statistics counters.
  // On a bubble only valid/ctrl/op are cleared: the datapath fields are
  // don't-care downstream and are left untouched to avoid needless toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= {CTRL_W{1'b0}};
      ex_op      <= {OP_W{1'b0}};
      ex_a       <= {DATA_W{1'b0}};
      ex_b       <= {DATA_W{1'b0}};
      ex_ext     <= {DATA_W{1'b0}};
      ex_index   <= {DATA_W{1'b0}};
      ex_pc      <= {DATA_W{1'b0}};
      ex_rs      <= {REG_W{1'b0}};
      ex_rt      <= {REG_W{1'b0}};
      ex_rd      <= {REG_W{1'b0}};
      bubble_cnt <= {CNT_W{1'b0}};
      flush_cnt  <= {CNT_W{1'b0}};
    end else begin
      case (action_s)
        ACT_FLUSH: begin
          ex_valid <= 1'b0;
          ex_ctrl  <= {CTRL_W{1'b0}};
          ex_op    <= {OP_W{1'b0}};
          // Only a real instruction being killed counts as a flush.
          if (id_valid) begin
            flush_cnt <= sat_inc(flush_cnt);
          end else begin
            flush_cnt <= flush_cnt;
          end
        end
        ACT_HOLD: begin
          ex_valid <= ex_valid;
        end
        ACT_BUBBLE: begin
          // ID instruction is not consumed; it is re-presented next cycle.
          ex_valid   <= 1'b0;
          ex_ctrl    <= {CTRL_W{1'b0}};
          ex_op      <= {OP_W{1'b0}};
          bubble_cnt <= sat_inc(bubble_cnt);
        end
        ACT_LOAD: begin
          ex_valid <= id_valid;
          ex_ctrl  <= id_valid ? id_ctrl : {CTRL_W{1'b0}};
          ex_op    <= id_op;
          ex_a     <= id_a;
          ex_b     <= id_b;
          ex_ext   <= id_ext;
          ex_index <= id_index;
          ex_pc    <= id_pc;
          ex_rs    <= id_rs;
          ex_rt    <= id_rt;
          ex_rd    <= id_rd;
        end
        default: begin
          ex_valid <= ex_valid;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

  localparam int DW      = 32;
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  localparam logic [10:0] LW  = 11'h40B;  // ALUsrc|memread|regwrite|memtoreg
  localparam logic [10:0] ADD = 11'h002;  // regwrite

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [10:0]   id_ctrl;
  logic [3:0]    id_op;
  logic [DW-1:0] id_a, id_b, id_ext, id_index, id_pc;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          id_uses_rt;
  logic          stall, flush;
  logic          ex_valid;
  logic [10:0]   ex_ctrl;
  logic [3:0]    ex_op;
  logic [DW-1:0] ex_a, ex_b, ex_ext, ex_index, ex_pc;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic          load_use;
  logic [CW-1:0] bubble_cnt, flush_cnt;

  int total;
  int bad;

  // Behavioural model of the EX-side contents.
  logic          m_valid;
  logic [10:0]   m_ctrl;
  logic [3:0]    m_op;
  logic [DW-1:0] m_a, m_b, m_ext, m_index, m_pc;
  logic [4:0]    m_rs, m_rt, m_rd;
  int            m_bcnt, m_fcnt;

  id_ex_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_op(id_op),
    .id_a(id_a), .id_b(id_b), .id_ext(id_ext), .id_index(id_index), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_op(ex_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_ext(ex_ext), .ex_index(ex_index), .ex_pc(ex_pc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .load_use(load_use), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_lu();
    return m_valid && m_ctrl[3] && (m_rt != 5'd0) && id_valid &&
           ((m_rt == id_rs) || (id_uses_rt && (m_rt == id_rt)));
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = 11'd0; m_op = 4'd0;
    m_a = '0; m_b = '0; m_ext = '0; m_index = '0; m_pc = '0;
    m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
    m_bcnt = 0; m_fcnt = 0;
  endtask

  task automatic check_state();
    chk("ex_valid", 64'(ex_valid), 64'(m_valid));
    chk("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
    chk("ex_op", 64'(ex_op), 64'(m_op));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bcnt));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_fcnt));
    if (m_valid) begin
      chk("ex_a", 64'(ex_a), 64'(m_a));
      chk("ex_b", 64'(ex_b), 64'(m_b));
      chk("ex_ext", 64'(ex_ext), 64'(m_ext));
      chk("ex_index", 64'(ex_index), 64'(m_index));
      chk("ex_pc", 64'(ex_pc), 64'(m_pc));
      chk("ex_rs", 64'(ex_rs), 64'(m_rs));
      chk("ex_rt", 64'(ex_rt), 64'(m_rt));
      chk("ex_rd", 64'(ex_rd), 64'(m_rd));
    end
  endtask

  // One clock: check the hazard output, take the edge, advance the model, check state.
  task automatic cycle();
    logic lu;
    #1;
    lu = exp_lu();
    chk("load_use", 64'(load_use), 64'(lu));
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0; m_ctrl = 11'd0; m_op = 4'd0;
      if (id_valid) m_fcnt = (m_fcnt < CNT_MAX) ? m_fcnt + 1 : CNT_MAX;
    end else if (stall) begin
      m_valid = m_valid;
    end else if (lu) begin
      m_valid = 1'b0; m_ctrl = 11'd0; m_op = 4'd0;
      m_bcnt = (m_bcnt < CNT_MAX) ? m_bcnt + 1 : CNT_MAX;
    end else begin
      m_valid = id_valid;
      m_ctrl  = id_valid ? id_ctrl : 11'd0;
      m_op = id_op; m_a = id_a; m_b = id_b; m_ext = id_ext;
      m_index = id_index; m_pc = id_pc;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
    end
    #1;
    check_state();
  endtask

  task automatic set_id(input logic v, input logic [10:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic u, input logic [DW-1:0] a);
    id_valid = v; id_ctrl = c; id_op = 4'($urandom);
    id_rs = rs; id_rt = rt; id_rd = 5'($urandom); id_uses_rt = u;
    id_a = a; id_b = $urandom; id_ext = $urandom; id_index = $urandom; id_pc = $urandom;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic set_random();
    logic [10:0] c;
    c = 11'($urandom);
    c[3] = ($urandom_range(0, 1) == 0);
    set_id(($urandom_range(0, 7) != 0), c, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom), $urandom);
    stall = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 9) == 0);
  endtask

  // Asynchronous reset in the middle of a cycle.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_a", 64'(ex_a), 64'd0);
    chk("rst_load_use", 64'(load_use), 64'd0);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    set_id(1'b0, 11'd0, 5'd0, 5'd0, 1'b0, '0);
    model_reset();
    #3;
    chk("reset_valid", 64'(ex_valid), 64'd0);
    chk("reset_ctrl", 64'(ex_ctrl), 64'd0);
    chk("reset_bcnt", 64'(bubble_cnt), 64'd0);
    chk("reset_fcnt", 64'(flush_cnt), 64'd0);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: lw rt=5 then add rs=5.
    set_id(1'b1, LW, 5'd1, 5'd5, 1'b0, 32'h100);
    cycle();
    set_id(1'b1, ADD, 5'd5, 5'd6, 1'b1, 32'h200);
    #1 chk("lu_req", 64'(load_use), 64'd1);
    cycle();
    chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
    chk("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);
    chk("lu_after_bubble", 64'(load_use), 64'd0);
    cycle();
    chk("lu_add_enters", 64'(ex_valid), 64'd1);
    chk("lu_add_rs", 64'(ex_rs), 64'd5);
    // Second dependent proceeds without another bubble.
    set_id(1'b1, ADD, 5'd5, 5'd7, 1'b1, 32'h300);
    #1 chk("dep2_no_lu", 64'(load_use), 64'd0);
    cycle();
    chk("dep2_bcnt", 64'(bubble_cnt), 64'd1);
    chk("dep2_a", 64'(ex_a), 64'h300);

    // r0 never hazards.
    set_id(1'b1, LW, 5'd0, 5'd0, 1'b0, 32'h10);
    cycle();
    set_id(1'b1, ADD, 5'd0, 5'd0, 1'b1, 32'h400);
    #1 chk("r0_no_lu", 64'(load_use), 64'd0);
    cycle();
    chk("r0_pass_valid", 64'(ex_valid), 64'd1);
    chk("r0_pass_a", 64'(ex_a), 64'h400);

    // Flush and stall together.
    set_id(1'b1, ADD, 5'd2, 5'd3, 1'b1, 32'h500);
    stall = 1'b1;
    flush = 1'b1;
    cycle();
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_cnt", 64'(flush_cnt), 64'd1);
    chk("flush_bcnt", 64'(bubble_cnt), 64'd1);

    // Three-cycle stall with a pending hazard.
    set_id(1'b1, LW, 5'd1, 5'd7, 1'b0, 32'h1234_5678);
    cycle();
    set_id(1'b1, ADD, 5'd7, 5'd2, 1'b1, 32'h55);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_lu", 64'(load_use), 64'd1);
      cycle();
      chk("stall_a", 64'(ex_a), 64'h1234_5678);
      chk("stall_valid", 64'(ex_valid), 64'd1);
      chk("stall_bcnt", 64'(bubble_cnt), 64'd1);
    end
    stall = 1'b0;
    cycle();
    chk("stall_release_bubble", 64'(bubble_cnt), 64'd2);

    // Saturation of the 4-bit bubble counter.
    for (int i = 0; i < 20; i++) begin
      set_id(1'b1, LW, 5'd1, 5'd3, 1'b0, $urandom);
      cycle();
      set_id(1'b1, ADD, 5'd3, 5'd0, 1'b0, $urandom);
      cycle();
    end
    chk("sat_bcnt", 64'(bubble_cnt), 64'd15);

    // Reset while a valid instruction sits in EX.
    set_id(1'b1, ADD, 5'd1, 5'd2, 1'b1, 32'h77);
    cycle();
    chk("pre_reset_valid", 64'(ex_valid), 64'd1);
    mid_reset();
    chk("post_reset_bcnt", 64'(bubble_cnt), 64'd0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      set_random();
      cycle();
      if (i % 997 == 500) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
